// File: rtl/board_pkg.sv
// Shared definitions for the game-board controller.
//   mode_t   : mode encodings driven onto board_ctrl.mode
//   KEY_*    : keypad bit positions inside the 16-bit key level bus
package board_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'b00,
    MODE_HELP  = 2'b01,
    MODE_SETUP = 2'b10,
    MODE_PLAY  = 2'b11
  } mode_t;

  localparam int KEY_UP     = 2;
  localparam int KEY_DOWN   = 6;
  localparam int KEY_LEFT   = 7;
  localparam int KEY_RIGHT  = 5;
  localparam int KEY_COMMIT = 10;
  localparam int KEY_COUNT  = 11;
  localparam int KEY_EXIT   = 12;
  localparam int KEY_BACK   = 13;
  localparam int KEY_NEXT   = 14;
  localparam int KEY_HELP   = 15;

endpackage

// File: rtl/key_edge.sv
// Rising-edge detector for debounced key levels.
//   clk   in  : system clock
//   rst_n in  : asynchronous active-low reset (clears history)
//   lvl   in  : W key levels, 1 = held
//   press out : W single-cycle pulses, high in the first cycle a key is seen held
module key_edge #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] lvl,
  output logic [W-1:0] press
);

  logic [W-1:0] lvl_q_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lvl_q_reg <= '0;
    else        lvl_q_reg <= lvl;
  end

  assign press = lvl & ~lvl_q_reg;

endmodule

// File: rtl/board_ctrl.sv
// Game-board controller: keypad edges -> IDLE/HELP/SETUP/PLAY mode FSM,
// an N_CELLS x CELL_W board with wrapping cursor and edit value, and a
// buzzer pulse of BEEP_CYCLES cycles on each commit.
//   clk        in  : system clock
//   rst_n      in  : asynchronous active-low reset
//   key_lvl    in  : 16 debounced key levels
//   board      out : cell i at [i*CELL_W +: CELL_W]
//   mode       out : 00 IDLE, 01 HELP, 10 SETUP, 11 PLAY
//   cursor     out : selected cell index
//   edit_val   out : value pending commit
//   active_cnt out : number of playable cells, 1..N_CELLS
//   beep       out : buzzer enable
module board_ctrl
  import board_pkg::*;
#(
  parameter  int N_CELLS     = 10,
  parameter  int CELL_W      = 4,
  parameter  int INIT_CELL   = 1,
  parameter  int BEEP_CYCLES = 5000000,
  localparam int IDX_W       = $clog2(N_CELLS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [15:0]                key_lvl,
  output logic [N_CELLS*CELL_W-1:0]  board,
  output logic [1:0]                 mode,
  output logic [IDX_W-1:0]           cursor,
  output logic [CELL_W-1:0]          edit_val,
  output logic [IDX_W:0]             active_cnt,
  output logic                       beep
);

  localparam int                BEEP_W    = $clog2(BEEP_CYCLES + 1);
  localparam logic [CELL_W-1:0] INIT_V    = CELL_W'(INIT_CELL);
  localparam logic [BEEP_W-1:0] BEEP_LOAD = BEEP_W'(BEEP_CYCLES);
  localparam logic [IDX_W:0]    ACNT_MAX  = (IDX_W+1)'(N_CELLS);

  logic [15:0]       press;
  mode_t             state_reg, state_next;
  logic [CELL_W-1:0] cells_reg [N_CELLS];
  logic [IDX_W-1:0]  cursor_reg, cursor_next;
  logic [CELL_W-1:0] edit_reg, edit_next;
  logic [IDX_W:0]    acnt_reg;
  logic [IDX_W:0]    last_idx;
  logic [BEEP_W-1:0] beep_cnt_reg;

  key_edge #(.W(16)) u_key_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .lvl   (key_lvl),
    .press (press)
  );

  // Keys with no function, collected so their non-use is explicit.
  logic unused_press;
  assign unused_press = ^{press[0], press[1], press[3], press[4], press[8], press[9]};

  // Exit wins over every other key in SETUP and PLAY.
  logic play_act, enter_play, count_hit, commit, mv_left, mv_right;
  assign play_act   = (state_reg == MODE_PLAY) && !press[KEY_EXIT];
  assign enter_play = (state_reg == MODE_SETUP) && !press[KEY_EXIT] && press[KEY_NEXT];
  assign count_hit  = (state_reg == MODE_SETUP) && !press[KEY_EXIT] && !press[KEY_NEXT]
                      && press[KEY_COUNT];
  assign commit     = play_act && press[KEY_COMMIT];
  assign mv_left    = play_act && press[KEY_LEFT] && !press[KEY_RIGHT];
  assign mv_right   = play_act && press[KEY_RIGHT] && !press[KEY_LEFT];

  // ---------------- mode FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= MODE_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      MODE_IDLE: begin
        if (press[KEY_NEXT])      state_next = MODE_SETUP;
        else if (press[KEY_HELP]) state_next = MODE_HELP;
      end
      MODE_HELP: begin
        if (press[KEY_NEXT])      state_next = MODE_SETUP;
        else if (press[KEY_BACK]) state_next = MODE_IDLE;
      end
      MODE_SETUP: begin
        if (press[KEY_EXIT])      state_next = MODE_IDLE;
        else if (press[KEY_NEXT]) state_next = MODE_PLAY;
      end
      MODE_PLAY: begin
        if (press[KEY_EXIT])      state_next = MODE_IDLE;
      end
      default: state_next = MODE_IDLE;
    endcase
  end

  always_comb begin
    mode = state_reg;
    beep = (beep_cnt_reg != '0);
  end

  // ---------------- cursor / edit value ----------------
  assign last_idx = acnt_reg - 1'b1;

  // A move overrides up/down; the edit value then shows the destination
  // cell as stored before any same-cycle commit lands.
  always_comb begin
    cursor_next = cursor_reg;
    edit_next   = edit_reg;
    if (mv_left)
      cursor_next = (cursor_reg == '0) ? last_idx[IDX_W-1:0] : cursor_reg - 1'b1;
    else if (mv_right)
      cursor_next = ({1'b0, cursor_reg} == last_idx) ? '0 : cursor_reg + 1'b1;

    if (mv_left || mv_right)
      edit_next = cells_reg[cursor_next];
    else if (play_act && press[KEY_UP] && !press[KEY_DOWN])
      edit_next = edit_reg + 1'b1;
    else if (play_act && press[KEY_DOWN] && !press[KEY_UP])
      edit_next = edit_reg - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cursor_reg   <= '0;
      edit_reg     <= INIT_V;
      acnt_reg     <= ACNT_MAX;
      beep_cnt_reg <= '0;
    end else begin
      if (enter_play) begin
        cursor_reg <= '0;
        edit_reg   <= INIT_V;
      end else if (play_act) begin
        cursor_reg <= cursor_next;
        edit_reg   <= edit_next;
      end

      if (count_hit)
        acnt_reg <= (acnt_reg == ACNT_MAX) ? (IDX_W+1)'(1) : acnt_reg + 1'b1;

      // Reload restarts the full pulse; mode changes do not touch it.
      if (commit)                  beep_cnt_reg <= BEEP_LOAD;
      else if (beep_cnt_reg != '0) beep_cnt_reg <= beep_cnt_reg - 1'b1;
    end
  end

  // ---------------- board cells ----------------
  generate
    for (genvar gi = 0; gi < N_CELLS; gi++) begin : g_cell
      logic wr;
      assign wr = commit && (cursor_reg == IDX_W'(gi)) && ((IDX_W+1)'(gi) < acnt_reg);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          cells_reg[gi] <= INIT_V;
        else if (enter_play) cells_reg[gi] <= INIT_V;
        else if (wr)         cells_reg[gi] <= edit_reg;
      end

      assign board[gi*CELL_W +: CELL_W] = cells_reg[gi];
    end
  endgenerate

  assign cursor     = cursor_reg;
  assign edit_val   = edit_reg;
  assign active_cnt = acnt_reg;

endmodule

// File: tb/tb_board_ctrl.sv
module tb_board_ctrl;

  localparam int N     = 10;
  localparam int W     = 4;
  localparam int INIT  = 1;
  localparam int BEEP  = 4;
  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [15:0]      key_lvl = '0;
  logic [N*W-1:0]   board;
  logic [1:0]       mode;
  logic [IDX_W-1:0] cursor;
  logic [W-1:0]     edit_val;
  logic [IDX_W:0]   active_cnt;
  logic             beep;

  board_ctrl #(.N_CELLS(N), .CELL_W(W), .INIT_CELL(INIT), .BEEP_CYCLES(BEEP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_lvl    (key_lvl),
    .board      (board),
    .mode       (mode),
    .cursor     (cursor),
    .edit_val   (edit_val),
    .active_cnt (active_cnt),
    .beep       (beep)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: plain integers and modular arithmetic.
  int          m_mode, m_cur, m_edit, m_acnt, m_beep;
  int          m_board [N];
  logic [15:0] m_prev;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  task automatic model_reset();
    m_mode = 0; m_cur = 0; m_edit = INIT; m_acnt = N; m_beep = 0; m_prev = '0;
    for (int i = 0; i < N; i++) m_board[i] = INIT;
  endtask

  task automatic model_step(input logic [15:0] lvl);
    logic [15:0] p;
    int ncur, nedit;
    bit fire;
    p = lvl & ~m_prev;
    m_prev = lvl;
    fire = 0;
    case (m_mode)
      0: if (p[14]) m_mode = 2; else if (p[15]) m_mode = 1;
      1: if (p[14]) m_mode = 2; else if (p[13]) m_mode = 0;
      2: begin
        if (p[12]) m_mode = 0;
        else if (p[14]) begin
          m_mode = 3; m_cur = 0; m_edit = INIT;
          for (int i = 0; i < N; i++) m_board[i] = INIT;
        end else if (p[11]) m_acnt = (m_acnt % N) + 1;
      end
      default: begin
        if (p[12]) m_mode = 0;
        else begin
          ncur = m_cur; nedit = m_edit;
          if (p[7] != p[5]) begin
            ncur  = p[5] ? (m_cur + 1) % m_acnt : (m_cur + m_acnt - 1) % m_acnt;
            nedit = m_board[ncur];
          end else if (p[2] != p[6]) begin
            nedit = p[2] ? (m_edit + 1) % 16 : (m_edit + 15) % 16;
          end
          if (p[10]) begin
            if (m_cur < m_acnt) m_board[m_cur] = m_edit;
            fire = 1;
          end
          m_cur = ncur; m_edit = nedit;
        end
      end
    endcase
    if (m_beep > 0) m_beep--;
    if (fire) m_beep = BEEP;
  endtask

  function automatic logic [N*W-1:0] model_board();
    logic [N*W-1:0] b;
    int v;
    for (int i = 0; i < N; i++) begin
      v = m_board[i];
      b[i*W +: W] = v[W-1:0];
    end
    return b;
  endfunction

  task automatic check_model();
    chk("model_mode", mode, m_mode);
    chk("model_cursor", cursor, m_cur);
    chk("model_edit_val", edit_val, m_edit);
    chk("model_active_cnt", active_cnt, m_acnt);
    chk("model_board", board, model_board());
    chk("model_beep", beep, (m_beep > 0));
  endtask

  // One clock: drive at negedge, sample 2 time units after the posedge.
  task automatic tick(input logic [15:0] lvl);
    @(negedge clk);
    key_lvl = lvl;
    model_step(lvl);
    @(posedge clk);
    #2;
    check_model();
  endtask

  task automatic note(string s);
    $display("txn %-14s mode=%0d cursor=%0d edit=%0d acnt=%0d beep=%0b board=%h",
             s, mode, cursor, edit_val, active_cnt, beep, board);
  endtask

  typedef struct {
    logic [15:0]      keys;
    logic [1:0]       mode;
    logic [IDX_W-1:0] cur;
    logic [W-1:0]     edit;
    logic [IDX_W:0]   acnt;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int hi;

    // navigation then wrap/edit, as {keys, mode, cursor, edit_val, active_cnt}
    tbl[0] = '{16'h8000, 2'd1, 4'd0, 4'd1, 5'd10};  // help
    tbl[1] = '{16'h2000, 2'd0, 4'd0, 4'd1, 5'd10};  // back
    tbl[2] = '{16'h4000, 2'd2, 4'd0, 4'd1, 5'd10};  // next
    tbl[3] = '{16'h0800, 2'd2, 4'd0, 4'd1, 5'd1};   // count wraps 10 -> 1
    tbl[4] = '{16'h0800, 2'd2, 4'd0, 4'd1, 5'd2};
    tbl[5] = '{16'h0800, 2'd2, 4'd0, 4'd1, 5'd3};
    tbl[6] = '{16'h4000, 2'd3, 4'd0, 4'd1, 5'd3};   // enter PLAY
    tbl[7] = '{16'h0080, 2'd3, 4'd2, 4'd1, 5'd3};   // left wraps 0 -> 2
    tbl[8] = '{16'h0004, 2'd3, 4'd2, 4'd2, 5'd3};   // up
    tbl[9] = '{16'h0004, 2'd3, 4'd2, 4'd3, 5'd3};   // up

    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_async_mode", mode, 2'd0);
    chk("reset_async_beep", beep, 1'b0);
    rst_n = 1'b1;
    tick(16'h0);
    chk("reset_mode", mode, 2'd0);
    chk("reset_cursor", cursor, 0);
    chk("reset_edit_val", edit_val, 1);
    chk("reset_active_cnt", active_cnt, 10);
    chk("reset_board", board, 40'h1111111111);
    chk("reset_beep", beep, 1'b0);
    note("reset");

    for (int i = 0; i < 10; i++) begin
      tick(tbl[i].keys);
      chk($sformatf("tbl%0d_mode", i), mode, tbl[i].mode);
      chk($sformatf("tbl%0d_cursor", i), cursor, tbl[i].cur);
      chk($sformatf("tbl%0d_edit_val", i), edit_val, tbl[i].edit);
      chk($sformatf("tbl%0d_active_cnt", i), active_cnt, tbl[i].acnt);
      chk($sformatf("tbl%0d_board", i), board, 40'h1111111111);
      note($sformatf("table%0d", i));
      tick(16'h0);
    end

    // commit: cell2 <= 3, beep exactly BEEP cycles
    tick(16'h0400);
    chk("commit_board", board, 40'h1111111311);
    hi = beep ? 1 : 0;
    repeat (8) begin
      tick(16'h0);
      if (beep) hi++;
    end
    chk("beep_length", hi, BEEP);
    note("commit");

    // right wraps 2 -> 0, edit loads cell0
    tick(16'h0020);
    chk("right_wrap_cursor", cursor, 0);
    chk("right_wrap_edit", edit_val, 1);
    note("right");
    tick(16'h0);

    // held right: one step only
    repeat (20) tick(16'h0020);
    tick(16'h0);
    chk("held_key_cursor", cursor, 1);
    note("held_right");

    tick(16'h0004);
    tick(16'h0);
    chk("up_edit", edit_val, 2);

    // commit+right: old cell gets old edit, then move
    tick(16'h0420);
    chk("commit_move_board", board, 40'h1111111321);
    chk("commit_move_cursor", cursor, 2);
    chk("commit_move_edit", edit_val, 3);
    note("commit_right");
    tick(16'h0);

    tick(16'h0044);
    chk("up_down_edit", edit_val, 3);
    note("up_down");
    tick(16'h0);

    tick(16'h1400);
    chk("exit_commit_mode", mode, 0);
    chk("exit_commit_board", board, 40'h1111111321);
    note("exit_commit");
    tick(16'h0);

    // back to PLAY, commit, then async reset mid-beep
    tick(16'h4000); tick(16'h0);
    tick(16'h4000); tick(16'h0);
    tick(16'h0004); tick(16'h0);
    tick(16'h0400); tick(16'h0);
    chk("pre_reset_beep", beep, 1'b1);
    chk("pre_reset_board", board, 40'h1111111112);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_beep", beep, 1'b0);
    chk("async_reset_mode", mode, 2'd0);
    chk("async_reset_board", board, 40'h1111111111);
    chk("async_reset_cursor", cursor, 0);
    chk("async_reset_active_cnt", active_cnt, 10);
    note("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick(16'h0);

    // random keys against the model
    for (int r = 0; r < 8; r++) begin
      repeat (50) tick(16'($urandom & $urandom & $urandom));
      note($sformatf("random%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
